control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit that drives every control input of the datapath module (upstream of the datapath).
//  Steps fetch T0-T2 and per-opcode execute T3-T7, one clock per step, decoding ir[31:27].
//  Replaces the hand-timed testbench control stepping and drives the datapath port-for-port.
// PARAMETERS
//  OPW   5   opcode width; opcode = ir[31:32-OPW]
//  IRW   32  instruction register width
// PORTS
//  clk            in   1    system clock, rising edge
//  clr            in   1    asynchronous active-high reset
//  ir             in   IRW  datapath IR contents; stable from T3 until next T2
//  mem_ready      in   1    memory handshake; present only with MEM_WAIT_EN
//  read, write    out  1    memory strobes
//  PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout, BAout, Rout  out 1 each  bus drivers
//  MARIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CIn, InIn, OutIn, ZIn, CONIn, RIn  out 1 each  reg loads
//  Gra, Grb, Grc  out  1    register-field select
//  add, subtract, multiply, divide, andSignal, orSignal  out 1 each  ALU op
//  run            out  1    1 unless in RESET or HALT
//  state          out  4    current step code, debug
// BEHAVIOUR
//  State register updates on posedge clk; outputs are combinational from state and opcode.
//  Every output is 0 when not listed. clr=1 forces RESET immediately, mid-step included; all outputs 0, run=0.
//  Codes: RESET=0000, T0..T7=0111..1110, HALT=1111.
//  RESET->T0 on the first clock with clr=0.
//  Fetch:
//   T0: PCout MARIn IncPC ZIn
//   T1: Zlowout PCIn read MDRIn
//   T2: MDRout IRIn
//  Execute from T3; the last listed step returns to T0:
//   add/sub/and/or: T3 Grb Rout YIn | T4 Grc Rout op ZIn | T5 Zlowout Gra RIn
//   addi/andi/ori:  T3 Grb Rout YIn | T4 Cout op ZIn | T5 Zlowout Gra RIn
//   ldi:            T3 Grb BAout YIn | T4 Cout add ZIn | T5 Zlowout Gra RIn
//   ld:  T3/T4 as ldi | T5 Zlowout MARIn | T6 read MDRIn | T7 MDRout Gra RIn
//   st:  T3/T4 as ldi | T5 Zlowout MARIn | T6 Gra Rout MDRIn | T7 MDRout write
//   mul/div:        T3 Gra Rout YIn | T4 Grb Rout multiply|divide ZIn | T5 Zlowout LoIn | T6 Zhighout HiIn
//   mfhi/mflo: T3 HIout|LOout Gra RIn;  in: T3 IN_Portout Gra RIn;  out: T3 Gra Rout OutIn
//   nop, undefined opcode: T3 with no strobes -> T0
//   halt: T3 -> HALT; HALT is sticky with outputs 0 and run=0; only clr exits it
//  Latency in cycles including fetch: ALU/imm/ldi 6; ld/st 8; mul/div 7; mf/in/out/nop 4.
// CONFIGURATION
//  MEM_WAIT_EN defined:
//   - mem_ready port exists.
//   - Steps asserting read or write (T1, ld T6, st T7) hold state with unchanged outputs until mem_ready=1 at a posedge.
//   - clr still aborts at once.
//  MEM_WAIT_EN undefined:
//   - No mem_ready port; every step is exactly one cycle.
// STRUCTURE
//  Package cpu_ctrl_pkg holds:
//   - state codes
//   - opcode constants: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110,
//     addi 01100, andi 01101, ori 01110, mul 01111, div 10000, in 10110, out 10111,
//     mfhi 11000, mflo 11001, nop 11010, halt 11011
//  One sub-module, ctrl_decode:
//   - purely combinational (state, opcode) -> strobe vector
//   - control_sequencer keeps the state register and next-state logic
// TESTING
//  1. clr=1 for 2 clk, then 0 -> RESET, then T0 on first clk; all outputs 0 in RESET; T0 has PCout=MARIn=IncPC=ZIn=1.
//  2. ir=32'h1000_0000 (st) -> T3..T7 match the st row; write=1 only in T7; back to T0 after 8 cycles.
//  3. ir opcode add (00011) -> Grc=Rout=add=ZIn=1 in T4; Gra=RIn=1 in T5; T0 at cycle 6.
//  4. mul (01111) -> LoIn in T5 and HiIn in T6, never in the same cycle; T0 at cycle 7.
//  5. halt (11011) -> HALT and run=0 for 20 cycles; assert clr mid-T4 of the next instruction -> RESET async.
//  6. MEM_WAIT_EN: mem_ready=0 for 3 cycles during T1 -> T1 held 4 cycles with read=1; undefined opcode 11111 -> behaves as nop.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the hardwired control sequencer: step codes, opcodes and the strobe vector.
// The MEM_WAIT_EN build option is handled in control_sequencer; nothing here depends on it.
package cpu_ctrl_pkg;

   localparam int OPW = 5;
   localparam int IRW = 32;

   typedef enum logic [3:0] {
      S_RESET = 4'b0000,
      S_T0    = 4'b0111,
      S_T1    = 4'b1000,
      S_T2    = 4'b1001,
      S_T3    = 4'b1010,
      S_T4    = 4'b1011,
      S_T5    = 4'b1100,
      S_T6    = 4'b1101,
      S_T7    = 4'b1110,
      S_HALT  = 4'b1111
   } state_e;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef struct packed {
      logic read;
      logic write;
      logic pc_out;
      logic z_low_out;
      logic z_high_out;
      logic mdr_out;
      logic c_out;
      logic in_port_out;
      logic lo_out;
      logic hi_out;
      logic ba_out;
      logic r_out;
      logic mar_in;
      logic pc_in;
      logic mdr_in;
      logic ir_in;
      logic y_in;
      logic inc_pc;
      logic hi_in;
      logic lo_in;
      logic c_in;
      logic in_in;
      logic out_in;
      logic z_in;
      logic con_in;
      logic r_in;
      logic gra;
      logic grb;
      logic grc;
      logic alu_add;
      logic alu_sub;
      logic alu_mul;
      logic alu_div;
      logic alu_and;
      logic alu_or;
   } ctrl_s;

   localparam int CTRL_W = $bits(ctrl_s);

   // Final execute step per opcode; anything unlisted (nop, I/O, moves, undefined) ends at T3.
   function automatic state_e last_step(input logic [4:0] op);
      case (op)
         OP_LD, OP_ST:   last_step = S_T7;
         OP_MUL, OP_DIV: last_step = S_T6;
         OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_ADDI, OP_ANDI, OP_ORI: last_step = S_T5;
         default:        last_step = S_T3;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode from (step, opcode); all strobes low in RESET and HALT.
module ctrl_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int OPW_P = OPW
) (
   input  logic [3:0]        state_i,
   input  logic [OPW_P-1:0]  opcode_i,
   output logic [CTRL_W-1:0] ctrl_o
);

   ctrl_s c;

   always_comb begin
      c = '0;
      case (state_i)
         S_T0: begin
            c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1;
         end
         S_T1: begin
            c.z_low_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1;
         end
         S_T2: begin
            c.mdr_out = 1'b1; c.ir_in = 1'b1;
         end
         S_T3: begin
            case (opcode_i)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                  c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
               end
               OP_LD, OP_LDI, OP_ST: begin
                  c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
               end
               OP_MUL, OP_DIV: begin
                  c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
               end
               OP_MFHI: begin c.hi_out = 1'b1;      c.gra = 1'b1; c.r_in = 1'b1; end
               OP_MFLO: begin c.lo_out = 1'b1;      c.gra = 1'b1; c.r_in = 1'b1; end
               OP_IN:   begin c.in_port_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
               OP_OUT:  begin c.gra = 1'b1; c.r_out = 1'b1; c.out_in = 1'b1; end
               default: ;
            endcase
         end
         S_T4: begin
            case (opcode_i)
               OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                  c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1;
               end
               OP_ADDI, OP_ANDI, OP_ORI, OP_LD, OP_LDI, OP_ST: begin
                  c.c_out = 1'b1; c.z_in = 1'b1;
               end
               OP_MUL, OP_DIV: begin
                  c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1;
               end
               default: ;
            endcase
            // Address arithmetic for memory ops reuses the adder.
            c.alu_add = (opcode_i == OP_ADD) || (opcode_i == OP_ADDI) ||
                        (opcode_i == OP_LD)  || (opcode_i == OP_LDI) || (opcode_i == OP_ST);
            c.alu_sub = (opcode_i == OP_SUB);
            c.alu_and = (opcode_i == OP_AND) || (opcode_i == OP_ANDI);
            c.alu_or  = (opcode_i == OP_OR)  || (opcode_i == OP_ORI);
            c.alu_mul = (opcode_i == OP_MUL);
            c.alu_div = (opcode_i == OP_DIV);
         end
         S_T5: begin
            case (opcode_i)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
                  c.z_low_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
               end
               OP_LD, OP_ST: begin
                  c.z_low_out = 1'b1; c.mar_in = 1'b1;
               end
               OP_MUL, OP_DIV: begin
                  c.z_low_out = 1'b1; c.lo_in = 1'b1;
               end
               default: ;
            endcase
         end
         S_T6: begin
            case (opcode_i)
               OP_LD:          begin c.read = 1'b1; c.mdr_in = 1'b1; end
               OP_ST:          begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
               OP_MUL, OP_DIV: begin c.z_high_out = 1'b1; c.hi_in = 1'b1; end
               default: ;
            endcase
         end
         S_T7: begin
            case (opcode_i)
               OP_LD:   begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
               OP_ST:   begin c.mdr_out = 1'b1; c.write = 1'b1; end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign ctrl_o = c;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute step sequencer driving every datapath control input.
// Build option MEM_WAIT_EN adds mem_ready and stalls read/write steps until it is high.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int OPW_P = OPW,
   parameter int IRW_P = IRW
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [IRW_P-1:0] ir,
`ifdef MEM_WAIT_EN
   input  logic             mem_ready,
`endif
   output logic read,
   output logic write,
   output logic PCout,
   output logic Zlowout,
   output logic Zhighout,
   output logic MDRout,
   output logic Cout,
   output logic IN_Portout,
   output logic LOout,
   output logic HIout,
   output logic BAout,
   output logic Rout,
   output logic MARIn,
   output logic PCIn,
   output logic MDRIn,
   output logic IRIn,
   output logic YIn,
   output logic IncPC,
   output logic HiIn,
   output logic LoIn,
   output logic CIn,
   output logic InIn,
   output logic OutIn,
   output logic ZIn,
   output logic CONIn,
   output logic RIn,
   output logic Gra,
   output logic Grb,
   output logic Grc,
   output logic add,
   output logic subtract,
   output logic multiply,
   output logic divide,
   output logic andSignal,
   output logic orSignal,
   output logic run,
   output logic [3:0] state
);

   state_e              state_q, state_d;
   logic [OPW_P-1:0]    opcode;
   logic [CTRL_W-1:0]   ctrl_vec;
   ctrl_s               ctrl;
   logic                stall;
   logic                unused_ir;

   assign opcode    = ir[IRW_P-1 -: OPW_P];
   assign unused_ir = ^ir[IRW_P-OPW_P-1:0];

   ctrl_decode #(.OPW_P(OPW_P)) u_decode (
      .state_i  (state_q),
      .opcode_i (opcode),
      .ctrl_o   (ctrl_vec)
   );

   assign ctrl = ctrl_s'(ctrl_vec);

`ifdef MEM_WAIT_EN
   assign stall = (ctrl.read | ctrl.write) & ~mem_ready;
`else
   assign stall = 1'b0;
`endif

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state_q <= S_RESET;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET: state_d = S_T0;
         S_T0:    state_d = S_T1;
         S_T1:    state_d = S_T2;
         S_T2:    state_d = S_T3;
         S_T3, S_T4, S_T5, S_T6, S_T7: begin
            if (state_q == S_T3 && opcode == OP_HALT) state_d = S_HALT;
            else if (state_q == last_step(opcode))    state_d = S_T0;
            else                                      state_d = state_e'(state_q + 4'd1);
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RESET;
      endcase
      // A pending memory handshake freezes the step, outputs included.
      if (stall) state_d = state_q;
   end

   assign run   = (state_q != S_RESET) && (state_q != S_HALT);
   assign state = state_q;

   assign read       = ctrl.read;
   assign write      = ctrl.write;
   assign PCout      = ctrl.pc_out;
   assign Zlowout    = ctrl.z_low_out;
   assign Zhighout   = ctrl.z_high_out;
   assign MDRout     = ctrl.mdr_out;
   assign Cout       = ctrl.c_out;
   assign IN_Portout = ctrl.in_port_out;
   assign LOout      = ctrl.lo_out;
   assign HIout      = ctrl.hi_out;
   assign BAout      = ctrl.ba_out;
   assign Rout       = ctrl.r_out;
   assign MARIn      = ctrl.mar_in;
   assign PCIn       = ctrl.pc_in;
   assign MDRIn      = ctrl.mdr_in;
   assign IRIn       = ctrl.ir_in;
   assign YIn        = ctrl.y_in;
   assign IncPC      = ctrl.inc_pc;
   assign HiIn       = ctrl.hi_in;
   assign LoIn       = ctrl.lo_in;
   assign CIn        = ctrl.c_in;
   assign InIn       = ctrl.in_in;
   assign OutIn      = ctrl.out_in;
   assign ZIn        = ctrl.z_in;
   assign CONIn      = ctrl.con_in;
   assign RIn        = ctrl.r_in;
   assign Gra        = ctrl.gra;
   assign Grb        = ctrl.grb;
   assign Grc        = ctrl.grc;
   assign add        = ctrl.alu_add;
   assign subtract   = ctrl.alu_sub;
   assign multiply   = ctrl.alu_mul;
   assign divide     = ctrl.alu_div;
   assign andSignal  = ctrl.alu_and;
   assign orSignal   = ctrl.alu_or;

endmodule
